// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer feeding an AXI-stream FFT core from an ADC sample strobe.
// Optional DC removal (offset-binary to two's complement) when FEEDER_DC_REMOVE_EN is defined.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 1024,
    parameter int AD_W      = 10
) (
    input  logic            fft_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            cont,
    input  logic [AD_W-1:0] ad_data,
    input  logic            ad_valid,
    output logic [31:0]     m_axis_data_tdata,
    output logic            m_axis_data_tvalid,
    input  logic            m_axis_data_tready,
    output logic            m_axis_data_tlast,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {FILL_IDLE, FILL_FILL, FILL_WAIT} fill_state_t;
    typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_PREFETCH, DRAIN_STREAM} drain_state_t;

    fill_state_t  fill_state_reg, fill_state_next;
    drain_state_t drain_state_reg, drain_state_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          fill_bank_reg, fill_bank_next;
    logic          drain_bank_reg, drain_bank_next;
    logic          cont_reg, cont_next;
    logic          overrun_reg, overrun_next;
    logic          tvalid_reg, tvalid_next;

    logic          wr_en, handoff;
    logic          start_ok, stop_req, cont_eff;
    logic          beat_hs, last_hs, drain_free;
    logic [PW-1:0] rd_addr;
    logic [15:0]   wr_data;
    logic [15:0]   ram_q;
    logic [15:0]   bank_q [2];

    assign busy     = (fill_state_reg != FILL_IDLE) || (drain_state_reg != DRAIN_IDLE);
    assign start_ok = start && !busy;
    // A start with cont=0 while running is a stop request for continuous mode.
    assign stop_req = start && busy && !cont;
    assign cont_eff = cont_reg && !stop_req;

    assign beat_hs    = tvalid_reg && m_axis_data_tready;
    assign last_hs    = beat_hs && (rd_ptr_reg == LAST_IDX);
    assign drain_free = (drain_state_reg == DRAIN_IDLE) || last_hs;

`ifdef FEEDER_DC_REMOVE_EN
    localparam int MID = 1 << (AD_W - 1);
    logic [AD_W:0] dc_diff;
    assign dc_diff = {1'b0, ad_data} - (AD_W + 1)'(MID);
    assign wr_data = 16'($signed(dc_diff));
`else
    assign wr_data = 16'(ad_data);
`endif

    // Read address runs one ahead on a handshake so the next beat is ready without a bubble.
    assign rd_addr = beat_hs ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [15:0] mem [FRAME_LEN];
            logic [15:0] q_reg;
            always_ff @(posedge fft_clk) begin
                if (wr_en && (fill_bank_reg == 1'(gi)))
                    mem[wr_ptr_reg] <= wr_data;
                q_reg <= mem[rd_addr];
            end
            assign bank_q[gi] = q_reg;
        end
    endgenerate

    assign ram_q = bank_q[drain_bank_reg];

    always_comb begin
        fill_state_next  = fill_state_reg;
        drain_state_next = drain_state_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        fill_bank_next   = fill_bank_reg;
        drain_bank_next  = drain_bank_reg;
        cont_next        = cont_eff;
        overrun_next     = overrun_reg;
        tvalid_next      = tvalid_reg;
        wr_en            = 1'b0;
        handoff          = 1'b0;

        case (fill_state_reg)
            FILL_IDLE: begin
                if (start_ok) begin
                    fill_state_next = FILL_FILL;
                    wr_ptr_next     = '0;
                    cont_next       = cont;
                    overrun_next    = 1'b0;
                end
            end
            FILL_FILL: begin
                if (ad_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (wr_ptr_reg == LAST_IDX) begin
                        if (drain_free) begin
                            handoff         = 1'b1;
                            fill_bank_next  = ~fill_bank_reg;
                            fill_state_next = cont_eff ? FILL_FILL : FILL_IDLE;
                        end else begin
                            fill_state_next = FILL_WAIT;
                        end
                    end
                end
            end
            FILL_WAIT: begin
                if (ad_valid)
                    overrun_next = 1'b1;
                if (drain_free) begin
                    handoff         = 1'b1;
                    fill_bank_next  = ~fill_bank_reg;
                    wr_ptr_next     = '0;
                    fill_state_next = cont_eff ? FILL_FILL : FILL_IDLE;
                end
            end
            default: fill_state_next = FILL_IDLE;
        endcase

        case (drain_state_reg)
            DRAIN_PREFETCH: drain_state_next = DRAIN_STREAM;
            DRAIN_STREAM: begin
                tvalid_next = 1'b1;
                if (beat_hs) begin
                    if (rd_ptr_reg == LAST_IDX) begin
                        tvalid_next      = 1'b0;
                        drain_state_next = DRAIN_IDLE;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A handoff coinciding with the final beat restarts the drain immediately.
        if (handoff) begin
            drain_state_next = DRAIN_PREFETCH;
            drain_bank_next  = fill_bank_reg;
            rd_ptr_next      = '0;
            tvalid_next      = 1'b0;
        end
    end

    always_ff @(posedge fft_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fill_state_reg  <= FILL_IDLE;
            drain_state_reg <= DRAIN_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fill_bank_reg   <= 1'b0;
            drain_bank_reg  <= 1'b0;
            cont_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            tvalid_reg      <= 1'b0;
        end else begin
            fill_state_reg  <= fill_state_next;
            drain_state_reg <= drain_state_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            fill_bank_reg   <= fill_bank_next;
            drain_bank_reg  <= drain_bank_next;
            cont_reg        <= cont_next;
            overrun_reg     <= overrun_next;
            tvalid_reg      <= tvalid_next;
        end
    end

    assign m_axis_data_tvalid = tvalid_reg;
    assign m_axis_data_tdata  = tvalid_reg ? {16'h0000, ram_q} : 32'h0;
    assign m_axis_data_tlast  = tvalid_reg && (rd_ptr_reg == LAST_IDX);
    assign frame_done         = last_hs;
    assign overrun            = overrun_reg;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder with FRAME_LEN=8, AD_W=10.
// Expected beats are queued as samples are driven and popped by a negedge monitor.
module tb_fft_frame_feeder;
    localparam int FL = 8;

    logic        fft_clk;
    logic        sys_rst;
    logic        start;
    logic        cont;
    logic [9:0]  ad_data;
    logic        ad_valid;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    fft_frame_feeder #(.FRAME_LEN(FL), .AD_W(10)) dut (
        .fft_clk            (fft_clk),
        .sys_rst            (sys_rst),
        .start              (start),
        .cont               (cont),
        .ad_data            (ad_data),
        .ad_valid           (ad_valid),
        .m_axis_data_tdata  (tdata),
        .m_axis_data_tvalid (tvalid),
        .m_axis_data_tready (tready),
        .m_axis_data_tlast  (tlast),
        .busy               (busy),
        .frame_done         (frame_done),
        .overrun            (overrun)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t extra_q[$];
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int lo_cnt = 0;
    int pat_mode = 0;

    initial begin
        fft_clk = 1'b0;
        forever #5 fft_clk = ~fft_clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_real(input int v);
`ifdef FEEDER_DC_REMOVE_EN
        int d;
        d = v - 512;
        return 16'(d);
`else
        return 16'(v);
`endif
    endfunction

    // tready: optional forced-low window, then always-1 or a 1,0,0 pattern
    initial begin
        int pat;
        pat = 0;
        tready = 1'b1;
        forever begin
            @(posedge fft_clk);
            #1;
            if (lo_cnt > 0) begin
                tready = 1'b0;
                lo_cnt--;
            end else if (pat_mode != 0) begin
                tready = (pat % 3 == 0);
                pat++;
            end else begin
                tready = 1'b1;
            end
        end
    end

    // Monitor: compare the presented beat against the scoreboard head on every valid cycle
    initial begin
        forever begin
            @(negedge fft_clk);
            if (!sys_rst && tvalid) begin
                if (exp_q.size() > 0) begin
                    check_value("tdata", tdata, exp_q[0].data);
                    check_value("tlast", 32'(tlast), 32'(exp_q[0].last));
                    check_value("frame_done", 32'(frame_done), 32'(tready && exp_q[0].last));
                    if (tready) begin
                        $display("beat %0d tdata=%h tlast=%b", beats_seen, tdata, tlast);
                        beats_seen++;
                        void'(exp_q.pop_front());
                    end
                end else if (tready) begin
                    $display("beat %0d tdata=%h tlast=%b (unqueued)", beats_seen, tdata, tlast);
                    extra_q.push_back('{last: tlast, data: tdata});
                    beats_seen++;
                end
            end
            if (!sys_rst && frame_done)
                done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        sys_rst  = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        ad_valid = 1'b0;
        ad_data  = '0;
        repeat (2) @(posedge fft_clk);
        #1;
        sys_rst = 1'b0;
        exp_q.delete();
        extra_q.delete();
        done_cnt   = 0;
        beats_seen = 0;
    endtask

    task automatic start_pulse(input logic c);
        start = 1'b1;
        cont  = c;
        @(posedge fft_clk);
        #1;
        start = 1'b0;
    endtask

    // Drive n ramp samples from base; optional stop request at index stop_at; queue the first push_n
    task automatic feed(input int base, input int n, input int gap, input int stop_at, input int push_n);
        for (int i = 0; i < n; i++) begin
            ad_data  = 10'(base + i);
            ad_valid = 1'b1;
            if (i == stop_at) begin
                start = 1'b1;
                cont  = 1'b0;
            end
            if (i < push_n)
                exp_q.push_back('{last: (i % FL == FL - 1), data: {16'h0, exp_real(base + i)}});
            @(posedge fft_clk);
            #1;
            ad_valid = 1'b0;
            start    = 1'b0;
            repeat (gap) begin
                @(posedge fft_clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while ((busy || exp_q.size() > 0) && k < maxc) begin
            @(posedge fft_clk);
            #1;
            k++;
        end
        check_value("busy_end", 32'(busy), 32'(0));
        check_value("pending_beats", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int s0;
        int k;
        int dc_vals[8];
        dc_vals = '{512, 0, 1023, 1, 2, 511, 513, 3};

        // reset state
        sys_rst  = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        ad_valid = 1'b0;
        ad_data  = '0;
        repeat (2) @(posedge fft_clk);
        #1;
        check_value("rst_tvalid", 32'(tvalid), 0);
        check_value("rst_tlast", 32'(tlast), 0);
        check_value("rst_tdata", tdata, 0);
        check_value("rst_busy", 32'(busy), 0);
        check_value("rst_frame_done", 32'(frame_done), 0);
        check_value("rst_overrun", 32'(overrun), 0);

        // single frame, ramp 0..7, plus handoff-to-tvalid latency
        do_reset();
        start_pulse(1'b0);
        check_value("busy_after_start", 32'(busy), 1);
        feed(0, FL, 0, -1, FL);
        lat = 0;
        while (!tvalid && lat < 10) begin
            @(posedge fft_clk);
            #1;
            lat++;
        end
        check_value("first_tvalid_latency", lat, 2);
        wait_idle(100);
        check_value("single_extra", extra_q.size(), 0);
        check_value("single_done_cnt", done_cnt, 1);
        check_value("single_overrun", 32'(overrun), 0);

        // backpressure with tready 1,0,0 pattern
        do_reset();
        pat_mode = 1;
        start_pulse(1'b0);
        feed(100, FL, 0, -1, FL);
        wait_idle(200);
        pat_mode = 0;
        check_value("bp_extra", extra_q.size(), 0);
        check_value("bp_done_cnt", done_cnt, 1);

        // continuous: three frames, stop requested during the third
        do_reset();
        start_pulse(1'b1);
        feed(0, 3 * FL, 1, 18, 3 * FL);
        wait_idle(200);
        check_value("cont_extra", extra_q.size(), 0);
        check_value("cont_done_cnt", done_cnt, 3);
        check_value("cont_overrun", 32'(overrun), 0);

        // overrun: tready held low while samples stream
        do_reset();
        lo_cnt = 22;
        start_pulse(1'b1);
        feed(0, 44, 0, 32, 2 * FL);
        wait_idle(300);
        check_value("ovr_overrun", 32'(overrun), 1);
        check_value("ovr_done_cnt", done_cnt, 3);
        check_value("ovr_extra_size", extra_q.size(), FL);
        s0 = -1;
        if (extra_q.size() > 0)
            for (int j = 2 * FL; j < 44; j++)
                if (exp_real(j) == extra_q[0].data[15:0])
                    s0 = j;
        check_value("ovr_resume_after_drop", 32'(s0 >= 2 * FL), 1);
        k = (extra_q.size() < FL) ? extra_q.size() : FL;
        for (int i = 0; i < k; i++) begin
            check_value("ovr_frame3_data", extra_q[i].data, {16'h0, exp_real(s0 + i)});
            check_value("ovr_frame3_last", 32'(extra_q[i].last), 32'(i == FL - 1));
        end

        // reset mid-drain after beat 3
        do_reset();
        start_pulse(1'b0);
        feed(0, FL, 0, -1, 4);
        k = 0;
        while (beats_seen < 4 && k < 200) begin
            @(posedge fft_clk);
            #1;
            k++;
        end
        check_value("rst_mid_beats", beats_seen, 4);
        sys_rst = 1'b1;
        #1;
        check_value("rst_mid_tvalid", 32'(tvalid), 0);
        check_value("rst_mid_tlast", 32'(tlast), 0);
        check_value("rst_mid_busy", 32'(busy), 0);
        @(posedge fft_clk);
        #1;
        sys_rst = 1'b0;
        repeat (20) @(posedge fft_clk);
        #1;
        check_value("rst_mid_extra", extra_q.size(), 0);
        check_value("rst_mid_done_cnt", done_cnt, 0);
        check_value("rst_mid_tvalid_after", 32'(tvalid), 0);

        // code boundaries 0, 512, 1023 (converted when DC removal is built in)
        do_reset();
        start_pulse(1'b0);
        for (int i = 0; i < FL; i++) begin
            ad_data  = 10'(dc_vals[i]);
            ad_valid = 1'b1;
            exp_q.push_back('{last: (i == FL - 1), data: {16'h0, exp_real(dc_vals[i])}});
            @(posedge fft_clk);
            #1;
        end
        ad_valid = 1'b0;
        wait_idle(100);
        check_value("dc_extra", extra_q.size(), 0);
        check_value("dc_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
